// File: rtl/buffer_idex_ctl.sv
// ID->EX pipeline register with a valid bit, stall (hold) and flush (bubble) control.
// Optional macro IDEX_PERF_EN adds saturating stall and bubble counters.
module buffer_idex_ctl #(
    parameter int XLEN    = 64,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 2,
    parameter int FUN3_W  = 3,
    parameter int FUN7_W  = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               nextValid,
    input  logic               nextAluSRC,
    input  logic               nextBranch,
    input  logic               nextMemWrite,
    input  logic               nextMemRead,
    input  logic               nextMemToReg,
    input  logic               nextRegWrite,
    input  logic [REG_AW-1:0]  nextWrReg,
    input  logic [REG_AW-1:0]  nextRs1,
    input  logic [REG_AW-1:0]  nextRs2,
    input  logic [XLEN-1:0]    nextPC,
    input  logic [XLEN-1:0]    nextReg1,
    input  logic [XLEN-1:0]    nextReg2,
    input  logic [XLEN-1:0]    nextInme,
    input  logic [ALUOP_W-1:0] nextAluOp,
    input  logic [FUN3_W-1:0]  nextFun3,
    input  logic [FUN7_W-1:0]  nextFun7,
    output logic               actValid,
    output logic               actAluSRC,
    output logic               actBranch,
    output logic               actMemWrite,
    output logic               actMemRead,
    output logic               actMemToReg,
    output logic               actRegWrite,
    output logic [REG_AW-1:0]  actWrReg,
    output logic [REG_AW-1:0]  actRs1,
    output logic [REG_AW-1:0]  actRs2,
    output logic [XLEN-1:0]    actPc,
    output logic [XLEN-1:0]    actReg1,
    output logic [XLEN-1:0]    actReg2,
    output logic [XLEN-1:0]    actInme,
    output logic [ALUOP_W-1:0] actAluOp,
    output logic [FUN3_W-1:0]  actFun3,
`ifdef IDEX_PERF_EN
    output logic [31:0]        stallCnt,
    output logic [31:0]        bubbleCnt,
`endif
    output logic [FUN7_W-1:0]  actFun7
);

    typedef struct packed {
        logic               valid;
        logic [5:0]         ctl;   // {AluSRC, Branch, MemWrite, MemRead, MemToReg, RegWrite}
        logic [REG_AW-1:0]  wrreg;
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    reg1;
        logic [XLEN-1:0]    reg2;
        logic [XLEN-1:0]    inme;
        logic [ALUOP_W-1:0] aluop;
        logic [FUN3_W-1:0]  fun3;
        logic [FUN7_W-1:0]  fun7;
    } slot_t;

    slot_t slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (flush) begin
            slot_d = '0;
        end else if (!stall) begin
            slot_d.valid = nextValid;
            // Controls are gated so an invalid slot can never write regfile/memory.
            slot_d.ctl   = nextValid ? {nextAluSRC, nextBranch, nextMemWrite,
                                        nextMemRead, nextMemToReg, nextRegWrite} : 6'b0;
            slot_d.wrreg = nextWrReg;
            slot_d.rs1   = nextRs1;
            slot_d.rs2   = nextRs2;
            slot_d.pc    = nextPC;
            slot_d.reg1  = nextReg1;
            slot_d.reg2  = nextReg2;
            slot_d.inme  = nextInme;
            slot_d.aluop = nextAluOp;
            slot_d.fun3  = nextFun3;
            slot_d.fun7  = nextFun7;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) slot_q <= '0;
        else     slot_q <= slot_d;
    end

    assign actValid    = slot_q.valid;
    assign actAluSRC   = slot_q.ctl[5];
    assign actBranch   = slot_q.ctl[4];
    assign actMemWrite = slot_q.ctl[3];
    assign actMemRead  = slot_q.ctl[2];
    assign actMemToReg = slot_q.ctl[1];
    assign actRegWrite = slot_q.ctl[0];
    assign actWrReg    = slot_q.wrreg;
    assign actRs1      = slot_q.rs1;
    assign actRs2      = slot_q.rs2;
    assign actPc       = slot_q.pc;
    assign actReg1     = slot_q.reg1;
    assign actReg2     = slot_q.reg2;
    assign actInme     = slot_q.inme;
    assign actAluOp    = slot_q.aluop;
    assign actFun3     = slot_q.fun3;
    assign actFun7     = slot_q.fun7;

`ifdef IDEX_PERF_EN
    logic [31:0] stallCnt_q, stallCnt_d, bubbleCnt_q, bubbleCnt_d;
    logic        stall_inc, bubble_inc;

    assign stall_inc  = stall & ~flush;
    assign bubble_inc = flush | (~stall & ~nextValid);

    always_comb begin
        stallCnt_d  = stallCnt_q;
        bubbleCnt_d = bubbleCnt_q;
        if (stall_inc && stallCnt_q != 32'hFFFF_FFFF)   stallCnt_d  = stallCnt_q + 32'd1;
        if (bubble_inc && bubbleCnt_q != 32'hFFFF_FFFF) bubbleCnt_d = bubbleCnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt_q  <= '0;
            bubbleCnt_q <= '0;
        end else begin
            stallCnt_q  <= stallCnt_d;
            bubbleCnt_q <= bubbleCnt_d;
        end
    end

    assign stallCnt  = stallCnt_q;
    assign bubbleCnt = bubbleCnt_q;
`endif

endmodule
